// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 synchronous FIFO transmit and receive paths.
package ft245_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArm     = 2'd1,
      StWrite   = 2'd2,
      StRelease = 2'd3
   } tx_state_e;

   // Cycles the FPGA drives the bus before the first WR# strobe.
   localparam int unsigned TurnaroundCycles = 1;
   localparam int unsigned TurnW            = 2;

   localparam logic StrobeIdle = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a look-ahead read port for a registered head.
import ft245_pkg::*;

module sync_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned WIDTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  head,
   output logic [WIDTH-1:0]  head_after_pop,
   output logic [ADDR_W:0]   level,
   output logic [ADDR_W:0]   level_next
);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   level_q;

   always_comb begin
      level_next = level_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         level_q <= level_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wdata;
   end

   assign head           = mem[rd_ptr_q];
   assign head_after_pop = mem[rd_ptr_q + ADDR_W'(1)];
   assign level          = level_q;

endmodule

// File: rtl/ft245_sync_tx.sv
// FT245 synchronous FIFO transmitter: buffers bytes and writes them to the FT232H when TXE# allows.
// Optional send-immediate pulse after an idle drain is built when FT245_SIWU_EN is defined.
import ft245_pkg::*;

module ft245_sync_tx #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned SIWU_IDLE = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              tx_enable,
   input  logic              ft_txe_n,
   output logic [7:0]        ft_data,
   output logic              ft_data_oe,
   output logic              ft_wr_n,
   output logic              ft_siwu_n,
   output logic [ADDR_W:0]   level,
   output logic              busy
);

   logic              push;
   logic              pop;
   logic [ADDR_W:0]   level_next;
   logic [7:0]        head;
   logic [7:0]        head_after_pop;

   tx_state_e         state_q, state_d;
   logic [TurnW-1:0]  ta_q, ta_d;
   logic              wr_n_q;
   logic              oe_q;
   logic [7:0]        data_q, data_d;

   assign in_ready = (level != (ADDR_W+1)'(DEPTH));
   assign push     = in_valid && in_ready;
   // The FT232H takes a byte on any edge where our strobe is low and it has space.
   assign pop      = !wr_n_q && !ft_txe_n;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (8)
   ) u_fifo (
      .clk            (clk),
      .rst            (rst),
      .push           (push),
      .pop            (pop),
      .wdata          (in_data),
      .head           (head),
      .head_after_pop (head_after_pop),
      .level          (level),
      .level_next     (level_next)
   );

   always_comb begin
      state_d = state_q;
      ta_d    = '0;
      unique case (state_q)
         StIdle: begin
            if (tx_enable && level != '0) state_d = StArm;
         end
         StArm: begin
            ta_d = ta_q + TurnW'(1);
            if (ta_q == TurnW'(TurnaroundCycles - 1)) state_d = StWrite;
         end
         StWrite: begin
            if (!(tx_enable && level_next != '0)) state_d = StRelease;
         end
         StRelease: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Keep ft_data equal to the entry that is at the head after this edge.
   always_comb begin
      data_d = data_q;
      if (level_next != '0) begin
         if (level == '0 || (pop && level == (ADDR_W+1)'(1))) begin
            data_d = in_data;
         end else if (pop) begin
            data_d = head_after_pop;
         end else begin
            data_d = head;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ta_q    <= '0;
         wr_n_q  <= StrobeIdle;
         oe_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ta_q    <= ta_d;
         wr_n_q  <= (state_d == StWrite) ? ~StrobeIdle : StrobeIdle;
         oe_q    <= (state_d != StIdle);
         data_q  <= data_d;
      end
   end

   assign ft_wr_n    = wr_n_q;
   assign ft_data_oe = oe_q;
   assign ft_data    = data_q;
   assign busy       = (state_q != StIdle) || (level != '0);

`ifdef FT245_SIWU_EN
   localparam int unsigned IdleW = $clog2(SIWU_IDLE + 1);

   logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
   logic             armed_q, armed_d;
   logic             siwu_n_q;
   logic             fire;

   // Counter saturates so a pulse held off by tx_enable is issued once it returns.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      armed_d    = armed_q;
      fire       = 1'b0;
      if (push || pop) begin
         idle_cnt_d = '0;
         armed_d    = 1'b1;
      end else if (state_q == StIdle && level == '0) begin
         if (idle_cnt_q != IdleW'(SIWU_IDLE)) idle_cnt_d = idle_cnt_q + IdleW'(1);
         if (armed_q && tx_enable && idle_cnt_d == IdleW'(SIWU_IDLE)) begin
            fire    = 1'b1;
            armed_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_q <= '0;
         armed_q    <= 1'b0;
         siwu_n_q   <= StrobeIdle;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         armed_q    <= armed_d;
         siwu_n_q   <= fire ? ~StrobeIdle : StrobeIdle;
      end
   end

   assign ft_siwu_n = siwu_n_q;
`else
   logic unused_siwu_cfg;
   assign unused_siwu_cfg = (SIWU_IDLE != 0);
   assign ft_siwu_n       = StrobeIdle;
`endif

endmodule

// File: tb/tb_ft245_sync_tx.sv
// Scoreboard bench for ft245_sync_tx: driver queues expected bytes, negedge monitor checks every write.
module tb_ft245_sync_tx;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              tx_enable;
   logic              ft_txe_n;
   logic [7:0]        ft_data;
   logic              ft_data_oe;
   logic              ft_wr_n;
   logic              ft_siwu_n;
   logic [ADDR_W:0]   level;
   logic              busy;

   ft245_sync_tx #(
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .SIWU_IDLE (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_enable  (tx_enable),
      .ft_txe_n   (ft_txe_n),
      .ft_data    (ft_data),
      .ft_data_oe (ft_data_oe),
      .ft_wr_n    (ft_wr_n),
      .ft_siwu_n  (ft_siwu_n),
      .level      (level),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];
   int         accepted    = 0;
   int         model_level = 0;
   bit         pend_push   = 0;
   bit         pend_pop    = 0;
   int         siwu_pulses = 0;
   bit         b_done      = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_n(input int n);
      repeat (n) step();
   endtask

   // Called 1 time unit after an edge; returns 1 time unit after the accepting edge.
   task automatic push_byte(input logic [7:0] b);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && guard < 500) begin
         step();
         guard++;
      end
      if (!in_ready) begin
         chk("push_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(b);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int guard = 0;
      while ((level != 0 || busy || exp_q.size() != 0) && guard < 400) begin
         step();
         guard++;
      end
      chk("drain_done", int'(level == 0 && !busy), 1);
      chk("sb_empty", exp_q.size(), 0);
   endtask

   // Reference model: occupancy = accepted pushes - accepted writes; writes leave in push order.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         model_level = 0;
         pend_push   = 0;
         pend_pop    = 0;
      end else begin
         model_level = model_level + int'(pend_push) - int'(pend_pop);
         chk("level", int'(level), model_level);
         chk("in_ready", int'(in_ready), int'(model_level != DEPTH));
         if (model_level > 0 && exp_q.size() > 0) chk("head", int'(ft_data), int'(exp_q[0]));
         if (!ft_wr_n) chk("oe_during_write", int'(ft_data_oe), 1);
         if (!ft_wr_n && !ft_txe_n) begin
            accepted++;
            if (exp_q.size() == 0) chk("accept_unexpected", 1, 0);
            else chk("accept_data", int'(ft_data), int'(exp_q.pop_front()));
         end
`ifdef FT245_SIWU_EN
         if (!ft_siwu_n) siwu_pulses++;
`else
         chk("siwu_idle", int'(ft_siwu_n), 1);
`endif
         pend_push = in_valid && in_ready;
         pend_pop  = !ft_wr_n && !ft_txe_n;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      tx_enable = 1'b1;
      ft_txe_n  = 1'b0;
      step_n(3);
      chk("rst_wr_n", int'(ft_wr_n), 1);
      chk("rst_oe", int'(ft_data_oe), 0);
      chk("rst_data", int'(ft_data), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_siwu", int'(ft_siwu_n), 1);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      step();

      // Single byte: IDLE -> ARM -> WRITE (one strobe) -> RELEASE -> IDLE.
      push_byte(8'hA5);
      chk("t1_idle_oe", int'(ft_data_oe), 0);
      chk("t1_level", int'(level), 1);
      step();
      chk("t1_arm_oe", int'(ft_data_oe), 1);
      chk("t1_arm_wr_n", int'(ft_wr_n), 1);
      step();
      chk("t1_write_wr_n", int'(ft_wr_n), 0);
      chk("t1_write_data", int'(ft_data), 8'hA5);
      step();
      chk("t1_rel_wr_n", int'(ft_wr_n), 1);
      chk("t1_rel_oe", int'(ft_data_oe), 1);
      chk("t1_rel_level", int'(level), 0);
      step();
      chk("t1_idle2_oe", int'(ft_data_oe), 0);
      chk("t1_idle2_busy", int'(busy), 0);

      // Fill to full with TXE# high, then a 16-cycle burst.
      ft_txe_n = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      chk("t2_full_level", int'(level), 16);
      chk("t2_full_ready", int'(in_ready), 0);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      step_n(3);
      in_valid = 1'b0;
      chk("t2_no_overflow", int'(level), 16);
      chk("t2_held_wr_n", int'(ft_wr_n), 0);
      a0 = accepted;
      ft_txe_n = 1'b0;
      step_n(16);
      chk("t2_burst_count", accepted - a0, 16);
      chk("t2_burst_level", int'(level), 0);
      chk("t2_burst_end_wr_n", int'(ft_wr_n), 1);
      wait_drain();

      // TXE# stall on byte 0x07.
      ft_txe_n = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      a0 = accepted;
      ft_txe_n = 1'b0;
      step_n(7);
      ft_txe_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("t3_stall_wr_n", int'(ft_wr_n), 0);
         chk("t3_stall_data", int'(ft_data), 8'h07);
         chk("t3_stall_level", int'(level), 9);
         step();
      end
      ft_txe_n = 1'b0;
      wait_drain();
      chk("t3_total", accepted - a0, 16);

      // tx_enable dropped on an accepting edge.
      ft_txe_n = 1'b1;
      for (int i = 0; i < 8; i++) push_byte(8'(8'h40 + i));
      chk("t4_write_wr_n", int'(ft_wr_n), 0);
      a0 = accepted;
      ft_txe_n = 1'b0;
      step_n(2);
      tx_enable = 1'b0;
      step();
      chk("t4_count", accepted - a0, 3);
      chk("t4_rel_wr_n", int'(ft_wr_n), 1);
      chk("t4_rel_oe", int'(ft_data_oe), 1);
      chk("t4_rel_level", int'(level), 5);
      step();
      chk("t4_oe_off", int'(ft_data_oe), 0);
      step_n(2);
      chk("t4_parked_oe", int'(ft_data_oe), 0);
      chk("t4_parked_level", int'(level), 5);
      tx_enable = 1'b1;
      step();
      chk("t4_arm_oe", int'(ft_data_oe), 1);
      chk("t4_arm_wr_n", int'(ft_wr_n), 1);
      step();
      chk("t4_resume_wr_n", int'(ft_wr_n), 0);
      chk("t4_resume_data", int'(ft_data), 8'h43);
      wait_drain();

      // Bypass: push and pop together at level 1.
      ft_txe_n = 1'b1;
      push_byte(8'h11);
      step_n(2);
      chk("t5_pre_wr_n", int'(ft_wr_n), 0);
      chk("t5_pre_level", int'(level), 1);
      ft_txe_n = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h3C;
      exp_q.push_back(8'h3C);
      step();
      in_valid = 1'b0;
      ft_txe_n = 1'b1;
      chk("t5_level", int'(level), 1);
      chk("t5_data", int'(ft_data), 8'h3C);
      chk("t5_wr_n", int'(ft_wr_n), 0);
      ft_txe_n = 1'b0;
      wait_drain();

      // Randomized traffic, TXE# and bus arbitration.
      b_done = 0;
      fork
         begin
            for (int c = 0; c < 3000 && !b_done; c++) begin
               step();
               ft_txe_n  = ($urandom_range(0, 3) == 0);
               tx_enable = ($urandom_range(0, 7) != 0);
            end
            ft_txe_n  = 1'b0;
            tx_enable = 1'b1;
         end
         begin
            for (int i = 0; i < 120; i++) begin
               if ($urandom_range(0, 2) == 0) step();
               push_byte(8'($urandom));
            end
            b_done = 1;
         end
      join
      wait_drain();

`ifdef FT245_SIWU_EN
      a0 = siwu_pulses;
      push_byte(8'h77);
      wait_drain();
      step_n(60);
      chk("t7_siwu_pulses", siwu_pulses - a0, 1);
`endif

      // Asynchronous reset mid-burst.
      ft_txe_n = 1'b1;
      for (int i = 0; i < 8; i++) push_byte(8'(8'h80 + i));
      ft_txe_n = 1'b0;
      step_n(3);
      rst = 1'b1;
      #1;
      chk("t8_wr_n", int'(ft_wr_n), 1);
      chk("t8_oe", int'(ft_data_oe), 0);
      chk("t8_level", int'(level), 0);
      chk("t8_data", int'(ft_data), 0);
      chk("t8_busy", int'(busy), 0);
      exp_q.delete();
      step_n(2);
      rst = 1'b0;
      step();
      chk("t8_post_level", int'(level), 0);
      chk("t8_post_wr_n", int'(ft_wr_n), 1);
      push_byte(8'h5A);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ft245_sync_tx.md
Name: ft245_sync_tx

Overview:
- FPGA-side transmitter for the FT232H FT245 synchronous FIFO interface: carries controller and pixel bytes to the host over ft_bus, gated by TXE#.
- Buffers bytes from the controller or readout path in a small FIFO.
- Drives WR#, the bus data, and a bus-output enable for the top-level tristate.
- Runs entirely in the ft_clkout (60 MHz) domain; the FT245 receive path shares the bus, and tx_enable arbitrates between the two.

Parameters:
- DEPTH, 16, FIFO depth in bytes, power of two, at least 4.
- ADDR_W, 4, log2(DEPTH).
- SIWU_IDLE, 32, idle cycles after drain before a send-immediate pulse (optional feature only).

Ports:
- clk  in  1  ft_clkout from the FT232H; all logic is on its rising edge.
- rst  in  1  Reset, asynchronous, active-high.
- in_data  in  8  Byte to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a byte; a push occurs when in_valid && in_ready.
- tx_enable  in  1  Bus granted to the transmitter. Low means the receive path owns the bus.
- ft_txe_n  in  1  FT232H TX FIFO has space, active low.
- ft_data  out  8  Byte presented on ft_bus.
- ft_data_oe  out  1  Drive ft_bus with ft_data.
- ft_wr_n  out  1  FT245 write strobe, active low.
- ft_siwu_n  out  1  Send-immediate, active low.
- level  out  ADDR_W+1  FIFO occupancy, 0..DEPTH.
- busy  out  1  State other than IDLE, or level != 0.

Behaviour:
- Reset values:
  - ft_wr_n=1, ft_siwu_n=1, ft_data_oe=0, ft_data=8'h00.
  - level=0, pointers=0, state=IDLE.
  - Any byte in flight is discarded.
- Flow control:
  - in_ready = (level != DEPTH), combinational from the level register.
  - A push when full is impossible, even if a pop happens in the same cycle.
- Accept rule: a byte is delivered at a rising edge where the registered ft_wr_n==0 and the sampled ft_txe_n==0. That edge is the pop.
- Data register:
  - ft_data is registered and always holds the FIFO head.
  - On pop, it loads the next entry.
  - If level==1 and a push coincides with the pop, it loads in_data (bypass).
  - If the FIFO is empty, ft_data holds its value.
- Level arithmetic: level_next = level + push - pop, computed with an ADDR_W+1-bit width. Pointers wrap modulo DEPTH.
- State machine:
  - IDLE (oe=0, wr_n=1): when tx_enable && level!=0, go to ARM.
  - ARM (oe=1, wr_n=1): one-cycle bus turnaround, then go to WRITE.
  - WRITE (oe=1, wr_n=0): stays while tx_enable && level_next!=0.
    - WR# is held low while TXE# is high; no byte is lost because pop requires TXE# low.
    - Back-to-back bytes are written one per cycle with no bubble.
    - Otherwise wr_n goes to 1 at the next edge and the state goes to RELEASE.
  - RELEASE (oe=1, wr_n=1): one cycle, then IDLE with oe=0.
- tx_enable dropping in WRITE:
  - A pop on that same edge still counts.
  - wr_n rises within one clk; ft_data_oe is released within two clks.
- ft_txe_n going high mid-burst: the head byte is retained and re-presented until accepted.
- Reset mid-burst: outputs return to reset values asynchronously; the FIFO is emptied.

Optional Feature:
- Macro: FT245_SIWU_EN.
- Defined:
  - An idle counter counts cycles with state==IDLE && level==0 since the last pop.
  - On reaching SIWU_IDLE, ft_siwu_n pulses low for exactly 1 clk, once per drain, so the host receives a short packet immediately.
  - Any push or pop clears the counter and re-arms the pulse.
  - No pulse is issued while tx_enable is low.
- Undefined: ft_siwu_n is tied to 1; no counter is present.

Decomposition:
- Shared package (ft245_pkg):
  - State encoding constants: IDLE, ARM, WRITE, RELEASE.
  - FT245 turnaround length constant (1).
  - Active-low strobe idle value.
- Sub-module sync_fifo (DEPTH/ADDR_W, push/pop, head output, level), reused later by the receive path. The state machine, bypass and SIWU logic stay in ft245_sync_tx.

Test Plan:
- Reset with tx_enable=1 and txe_n=0; push 8'hA5 -> ARM after 1 cycle, WRITE after 2. ft_data=A5 and wr_n=0 for exactly one cycle. Then RELEASE, then IDLE with oe=0; level returns to 0.
- Push 16 bytes 0x00..0x0F with txe_n=1 -> in_ready=0 at level 16. Release txe_n -> 16 consecutive cycles with wr_n=0, and the bytes are accepted in order.
- Mid-burst, hold txe_n=1 for 5 cycles at byte 0x07 -> wr_n stays 0, ft_data stays 07, level is unchanged. Once txe_n=0, 07 is accepted once with no duplicate.
- Mid-burst, drop tx_enable on an accepting edge -> that byte is counted, wr_n=1 next cycle, oe=0 one cycle later. Re-enable -> the burst resumes from the next byte via ARM.
- level==1 with a simultaneous push(0x3C) and pop -> the next ft_data is 3C and level stays 1.
- With FT245_SIWU_EN and SIWU_IDLE=32: drain the FIFO -> exactly one siwu_n low pulse 32 cycles after the last pop. With the macro undefined -> siwu_n is constantly 1. Assert rst mid-burst -> wr_n=1 and oe=0 immediately, level=0.
